// File: rtl/neuron_layer_sched_if.sv
// Signal bundle between the layer sequencer and its neighbours: layer input producer,
// weight memory, the shared neuron_run datapath and the next layer.
interface neuron_layer_sched_if #(
   parameter int unsigned N  = 16,
   parameter int unsigned M  = 8,
   parameter int unsigned W  = 8,
   parameter int unsigned AW = (M > 1) ? $clog2(M) : 1,
   parameter int unsigned SW = $clog2(M + 1)
);
   logic                  start;
   logic [N-1:0][W-1:0]   in_vec;
   logic                  busy;
   logic                  wt_rd;
   logic [AW-1:0]         wt_addr;
   logic [N-1:0][W-1:0]   wt_row;
   logic [W-1:0]          wt_max;
   logic [W-1:0]          wt_min;
   logic [N-1:0][W-1:0]   nr_in;
   logic [N-1:0][W-1:0]   nr_weights;
   logic [W-1:0]          nr_act_max;
   logic [W-1:0]          nr_act_min;
   logic [W-1:0]          nr_out;
   logic                  nr_sum_too_big;
   logic [M-1:0][W-1:0]   out_vec;
   logic                  out_valid;
   logic                  out_ready;
   logic [SW-1:0]         sat_count;

   // Environment side: producer, weight memory, datapath and consumer.
   modport master (
      output start, in_vec, wt_row, wt_max, wt_min, nr_out, nr_sum_too_big, out_ready,
      input  busy, wt_rd, wt_addr, nr_in, nr_weights, nr_act_max, nr_act_min,
             out_vec, out_valid, sat_count
   );

   modport slave (
      input  start, in_vec, wt_row, wt_max, wt_min, nr_out, nr_sum_too_big, out_ready,
      output busy, wt_rd, wt_addr, nr_in, nr_weights, nr_act_max, nr_act_min,
             out_vec, out_valid, sat_count
   );
endinterface

// File: rtl/neuron_layer_sched.sv
// Time-multiplexes one neuron_run datapath over the M neurons of a layer: fetch each
// weight row, present it to the datapath, capture the result, then hand off the layer.
module neuron_layer_sched #(
   parameter int unsigned N  = 16,
   parameter int unsigned M  = 8,
   parameter int unsigned W  = 8,
   parameter int unsigned AW = (M > 1) ? $clog2(M) : 1,
   parameter int unsigned SW = $clog2(M + 1)
) (
   input logic                  clk,
   input logic                  rst_n,
   neuron_layer_sched_if.slave  bus
);

   localparam logic [W-1:0]  Z2oMax = '1;
   localparam logic [AW-1:0] LastJ  = AW'(M - 1);

   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StCapt, StDone} state_e;

   state_e              state_q;
   logic [AW-1:0]       j_q;
   logic                busy_q;
   logic                wt_rd_q;
   logic                out_valid_q;
   logic [SW-1:0]       sat_q;
   logic [N-1:0][W-1:0] in_q;
   logic [N-1:0][W-1:0] wts_q;
   logic [W-1:0]        max_q;
   logic [W-1:0]        min_q;
   logic [M-1:0][W-1:0] out_vec_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         j_q         <= '0;
         busy_q      <= 1'b0;
         wt_rd_q     <= 1'b0;
         out_valid_q <= 1'b0;
         sat_q       <= '0;
         in_q        <= '0;
         wts_q       <= '0;
         max_q       <= '0;
         min_q       <= '0;
         out_vec_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  in_q    <= bus.in_vec;
                  j_q     <= '0;
                  sat_q   <= '0;
                  busy_q  <= 1'b1;
                  wt_rd_q <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StFetch: begin
               wt_rd_q <= 1'b0;
               state_q <= StLoad;
            end
            StLoad: begin
               wts_q   <= bus.wt_row;
               max_q   <= bus.wt_max;
               min_q   <= bus.wt_min;
               state_q <= StCapt;
            end
            StCapt: begin
               out_vec_q[j_q] <= bus.nr_out;
               // The datapath can leave its flag high on the low-clamp path, so only
               // a pinned-high output counts as saturation.
               if (bus.nr_sum_too_big && (bus.nr_out == Z2oMax)) begin
                  sat_q <= sat_q + SW'(1);
               end
               if (j_q == LastJ) begin
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  j_q     <= j_q + AW'(1);
                  wt_rd_q <= 1'b1;
                  state_q <= StFetch;
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.wt_rd      = wt_rd_q;
   assign bus.wt_addr    = j_q;
   assign bus.nr_in      = in_q;
   assign bus.nr_weights = wts_q;
   assign bus.nr_act_max = max_q;
   assign bus.nr_act_min = min_q;
   assign bus.out_vec    = out_vec_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.sat_count  = sat_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Bench for neuron_layer_sched: models the weight memory and the neuron_run datapath,
// and compares each layer result against a dot-product reference.
module tb_neuron_layer_sched;
   localparam int N = 16;
   localparam int M = 8;
   localparam int W = 8;

   typedef logic [N-1:0][W-1:0] row_t;
   typedef logic [M-1:0][W-1:0] layer_t;

   typedef struct {
      int       mode;
      int       exp_sat;
      int       ready_delay;
      bit       fetch_start;
      bit       done_start;
      int       probe_k;
      logic [7:0] probe_val;
   } case_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   neuron_layer_sched_if #(.N(N), .M(M), .W(W)) bus ();

   neuron_layer_sched #(.N(N), .M(M), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int     n_tests = 0;
   int     n_fail  = 0;
   row_t   cur_in;
   row_t   wmem [M];
   logic [W-1:0] wmax [M];
   logic [W-1:0] wmin [M];
   layer_t exp_vec;
   int     exp_sat_model;
   case_t  cases [4];

   // Scaled dot product, inputs unsigned, weights signed.
   function automatic int dot(input row_t x, input row_t w);
      int acc = 0;
      for (int i = 0; i < N; i++) acc += int'(x[i]) * int'($signed(w[i]));
      return acc >>> 10;
   endfunction

   // Weight memory: one-cycle read latency.
   always @(posedge clk) begin
      if (bus.wt_rd) begin
         bus.wt_row <= wmem[bus.wt_addr];
         bus.wt_max <= wmax[bus.wt_addr];
         bus.wt_min <= wmin[bus.wt_addr];
      end
   end

   // Datapath: clamps to the bounds; the flag stays high on the low-clamp path too.
   always_comb begin
      int s;
      int hi;
      int lo;
      s  = dot(bus.nr_in, bus.nr_weights);
      hi = int'($signed(bus.nr_act_max));
      lo = int'($signed(bus.nr_act_min));
      bus.nr_sum_too_big = (s > hi) || (s < lo);
      if (s > hi)                bus.nr_out = 8'hFF;
      else if (s < lo || s < 0)  bus.nr_out = 8'h00;
      else                       bus.nr_out = W'(s);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic setup(input int mode);
      int s;
      for (int i = 0; i < N; i++) begin
         if (mode == 2)      cur_in[i] = 8'h00;
         else if (mode == 4) cur_in[i] = W'($urandom_range(0, 255));
         else                cur_in[i] = 8'hFF;
      end
      for (int k = 0; k < M; k++) begin
         int c;
         c = 4 + 2 * k;
         if (mode == 3 || (mode == 1 && (k == 2 || k == 5))) c = 127;
         wmax[k] = 8'd100;
         wmin[k] = 8'd0;
         for (int i = 0; i < N; i++) begin
            if (mode == 4) wmem[k][i] = W'($urandom_range(0, 80) - 40);
            else           wmem[k][i] = W'(c);
         end
         if (mode == 4) begin
            wmax[k] = W'($urandom_range(10, 90));
            wmin[k] = W'($urandom_range(0, 20) - 10);
         end
      end
      exp_sat_model = 0;
      for (int k = 0; k < M; k++) begin
         s = dot(cur_in, wmem[k]);
         if (s > int'($signed(wmax[k]))) begin
            exp_vec[k] = 8'hFF;
            exp_sat_model++;
         end else if (s < int'($signed(wmin[k])) || s < 0) begin
            exp_vec[k] = 8'h00;
         end else begin
            exp_vec[k] = W'(s);
         end
      end
   endtask

   // Entered and left at a negedge while the block is idle.
   task automatic run_eval(input int ready_delay, input bit fetch_start, input bit done_start,
                           input int exp_sat);
      int c = 0;
      int rd_errs = 0;
      int addr_errs = 0;
      int nreads = 0;
      int stab_errs = 0;
      bus.in_vec = cur_in;
      bus.start  = 1'b1;
      @(negedge clk);
      c = 1;
      bus.start  = fetch_start;
      bus.in_vec = ~cur_in;
      while (!bus.out_valid && c < 200) begin
         if (bus.wt_rd !== ((c % 3 == 1) && (c <= 3 * M - 2))) rd_errs++;
         if (bus.wt_rd) begin
            if (int'(bus.wt_addr) != nreads) addr_errs++;
            nreads++;
         end
         @(negedge clk);
         bus.start = 1'b0;
         c++;
      end
      check("latency", c, 3 * M + 1);
      check("wt_rd_trace", rd_errs, 0);
      check("wt_addr_order", addr_errs, 0);
      check("read_count", nreads, M);
      check("out_vec", bus.out_vec, exp_vec);
      check("sat_count", bus.sat_count, exp_sat);
      check("busy_in_done", bus.busy, 1);
      for (int d = 0; d < ready_delay; d++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_vec !== exp_vec || !bus.busy) stab_errs++;
      end
      if (ready_delay > 0) check("done_hold_stable", stab_errs, 0);
      bus.out_ready = 1'b1;
      bus.start     = done_start;
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.start     = 1'b0;
      check("valid_after_hs", bus.out_valid, 0);
      check("busy_after_hs", bus.busy, 0);
      check("out_vec_held", bus.out_vec, exp_vec);
   endtask

   initial begin
      cases[0] = '{mode: 0, exp_sat: 0, ready_delay: 0,  fetch_start: 1, done_start: 1,
                   probe_k: 0, probe_val: 8'd15};
      cases[1] = '{mode: 1, exp_sat: 2, ready_delay: 10, fetch_start: 0, done_start: 0,
                   probe_k: 2, probe_val: 8'hFF};
      cases[2] = '{mode: 2, exp_sat: 0, ready_delay: 0,  fetch_start: 0, done_start: 1,
                   probe_k: 7, probe_val: 8'h00};
      cases[3] = '{mode: 3, exp_sat: 8, ready_delay: 3,  fetch_start: 1, done_start: 0,
                   probe_k: 4, probe_val: 8'hFF};

      bus.start     = 1'b0;
      bus.in_vec    = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_wt_rd", bus.wt_rd, 0);
      check("rst_wt_addr", bus.wt_addr, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_sat_count", bus.sat_count, 0);
      check("rst_out_vec", bus.out_vec, 0);
      check("rst_nr_in", bus.nr_in, 0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (cases[t]) begin
         setup(cases[t].mode);
         run_eval(cases[t].ready_delay, cases[t].fetch_start, cases[t].done_start,
                  cases[t].exp_sat);
         check("probe_neuron", bus.out_vec[cases[t].probe_k], cases[t].probe_val);
      end

      for (int r = 0; r < 6; r++) begin
         setup(4);
         run_eval(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), exp_sat_model);
      end

      // Abort during neuron 4's LOAD cycle.
      setup(0);
      bus.in_vec = cur_in;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (13) @(negedge clk);
      check("pre_abort_addr", bus.wt_addr, 4);
      rst_n = 1'b0;
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_wt_rd", bus.wt_rd, 0);
      check("abort_wt_addr", bus.wt_addr, 0);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_sat_count", bus.sat_count, 0);
      check("abort_out_vec", bus.out_vec, 0);
      check("abort_nr_in", bus.nr_in, 0);
      check("abort_nr_weights", bus.nr_weights, 0);
      check("abort_nr_bounds", {bus.nr_act_max, bus.nr_act_min}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_eval(0, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
